vec_issue_ctrl: RTL and testbench

- Command sequencer in front of VectorCoproc.
- Buffers decoded vector commands from the scalar core in a small FIFO and issues them to the coprocessor control inputs, one register write per cycle.
- Expands grouped commands (1-4 consecutive vector registers) into back-to-back beats.
- Accumulates the datapath zero flag per command and reports it to the core.

---
 rtl/vec_issue_ctrl.sv | 213 +++++++++++++++++++++
 tb/tb_vec_issue_ctrl.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/vec_issue_ctrl.sv
// Vector command sequencer: FIFO-buffered commands expanded into per-register beats.
// Optional counters under `VEC_ISSUE_STATS_EN` (stat_cmds, stat_beats, stat_full).
module vec_issue_ctrl #(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned REG_AW = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [3:0]        cmd_op,
  input  logic [REG_AW-1:0] cmd_rd,
  input  logic [REG_AW-1:0] cmd_rs,
  input  logic [REG_AW-1:0] cmd_rt,
  input  logic [4:0]        cmd_shamt,
  input  logic              cmd_sign,
  input  logic              cmd_use_scalar,
  input  logic [31:0]       cmd_scalar,
  input  logic [1:0]        cmd_group,
  output logic              vec_we,
  output logic [REG_AW-1:0] vec_addr_rd,
  output logic [REG_AW-1:0] vec_addr_rs,
  output logic [REG_AW-1:0] vec_addr_rt,
  output logic [3:0]        aluOp,
  output logic [4:0]        shamt,
  output logic              useSign,
  output logic [31:0]       scalar_val,
  output logic              use_scalar,
  input  logic              vec_zero,
  output logic              zero_valid,
  output logic              zero_flag,
  output logic              busy
`ifdef VEC_ISSUE_STATS_EN
  ,
  output logic [31:0]       stat_cmds,
  output logic [31:0]       stat_beats,
  output logic [31:0]       stat_full
`endif
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PW:0] CNT_FULL = (PW+1)'(DEPTH);

  typedef struct packed {
    logic [3:0]        op;
    logic [REG_AW-1:0] rd;
    logic [REG_AW-1:0] rs;
    logic [REG_AW-1:0] rt;
    logic [4:0]        shamt;
    logic              sign;
    logic              use_scalar;
    logic [31:0]       scalar;
    logic [1:0]        group;
  } cmd_t;

  typedef enum logic {IDLE = 1'b0, ISSUE = 1'b1} state_t;

  cmd_t          mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [PW:0]   count_q, count_d;

  state_t            state_q;
  logic              vec_we_q;
  logic [REG_AW-1:0] rd_q, rs_q, rt_q;
  logic [3:0]        op_q;
  logic [4:0]        shamt_q;
  logic              sign_q, use_scalar_q;
  logic [31:0]       scalar_q;
  logic [1:0]        beat_q, group_q;
  logic              acc_q, zero_valid_q, zero_flag_q;

  cmd_t in_cmd, head, next_cmd;
  logic push, fifo_push, pop, load, last_beat;

  assign in_cmd    = {cmd_op, cmd_rd, cmd_rs, cmd_rt, cmd_shamt, cmd_sign,
                      cmd_use_scalar, cmd_scalar, cmd_group};
  assign head      = mem_q[rd_ptr_q];
  assign cmd_ready = (count_q < CNT_FULL);
  assign push      = cmd_valid && cmd_ready;
  assign last_beat = (state_q == ISSUE) && (beat_q == group_q);

  // An idle sequencer with an empty FIFO takes the incoming command straight
  // from the ports, so it never occupies a FIFO slot.
  always_comb begin
    pop       = 1'b0;
    load      = 1'b0;
    fifo_push = push;
    next_cmd  = head;
    if (state_q == IDLE) begin
      if (count_q != '0) begin
        load = 1'b1;
        pop  = 1'b1;
      end else if (push) begin
        load      = 1'b1;
        fifo_push = 1'b0;
        next_cmd  = in_cmd;
      end
    end else if (last_beat && (count_q != '0)) begin
      load = 1'b1;
      pop  = 1'b1;
    end
  end

  always_comb begin
    case ({fifo_push, pop})
      2'b10:   count_d = count_q + (PW+1)'(1);
      2'b01:   count_d = count_q - (PW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (fifo_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)       rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (fifo_push) mem_q[wr_ptr_q] <= in_cmd;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      vec_we_q     <= 1'b0;
      rd_q         <= '0;
      rs_q         <= '0;
      rt_q         <= '0;
      op_q         <= '0;
      shamt_q      <= '0;
      sign_q       <= 1'b0;
      use_scalar_q <= 1'b0;
      scalar_q     <= '0;
      beat_q       <= '0;
      group_q      <= '0;
      acc_q        <= 1'b0;
      zero_valid_q <= 1'b0;
      zero_flag_q  <= 1'b0;
    end else begin
      zero_valid_q <= 1'b0;
      if (state_q == ISSUE) begin
        if (!last_beat) begin
          beat_q <= beat_q + 2'd1;
          rd_q   <= rd_q + 1'b1;
          rs_q   <= rs_q + 1'b1;
          if (!use_scalar_q) rt_q <= rt_q + 1'b1;
          acc_q  <= acc_q & vec_zero;
        end else begin
          zero_flag_q  <= acc_q & vec_zero;
          zero_valid_q <= 1'b1;
          state_q      <= IDLE;
          vec_we_q     <= 1'b0;
        end
      end
      // A load overrides the return to IDLE, chaining groups without a bubble.
      if (load) begin
        state_q      <= ISSUE;
        vec_we_q     <= 1'b1;
        rd_q         <= next_cmd.rd;
        rs_q         <= next_cmd.rs;
        rt_q         <= next_cmd.rt;
        op_q         <= next_cmd.op;
        shamt_q      <= next_cmd.shamt;
        sign_q       <= next_cmd.sign;
        use_scalar_q <= next_cmd.use_scalar;
        scalar_q     <= next_cmd.scalar;
        group_q      <= next_cmd.group;
        beat_q       <= '0;
        acc_q        <= 1'b1;
      end
    end
  end

  assign vec_we      = vec_we_q;
  assign vec_addr_rd = rd_q;
  assign vec_addr_rs = rs_q;
  assign vec_addr_rt = rt_q;
  assign aluOp       = op_q;
  assign shamt       = shamt_q;
  assign useSign     = sign_q;
  assign scalar_val  = scalar_q;
  assign use_scalar  = use_scalar_q;
  assign zero_valid  = zero_valid_q;
  assign zero_flag   = zero_flag_q;
  assign busy        = (count_q != '0) || (state_q == ISSUE);

`ifdef VEC_ISSUE_STATS_EN
  logic [31:0] stat_cmds_q, stat_beats_q, stat_full_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stat_cmds_q  <= '0;
      stat_beats_q <= '0;
      stat_full_q  <= '0;
    end else begin
      if (last_beat)               stat_cmds_q  <= stat_cmds_q + 32'd1;
      if (vec_we_q)                stat_beats_q <= stat_beats_q + 32'd1;
      if (cmd_valid && !cmd_ready) stat_full_q  <= stat_full_q + 32'd1;
    end
  end

  assign stat_cmds  = stat_cmds_q;
  assign stat_beats = stat_beats_q;
  assign stat_full  = stat_full_q;
`endif

endmodule

// File: tb/tb_vec_issue_ctrl.sv
// Scoreboard bench for vec_issue_ctrl: expected beats and completions are queued
// by the stimulus and consumed by a negedge monitor.
module tb_vec_issue_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid, cmd_ready;
  logic [3:0]  cmd_op;
  logic [2:0]  cmd_rd, cmd_rs, cmd_rt;
  logic [4:0]  cmd_shamt;
  logic        cmd_sign, cmd_use_scalar;
  logic [31:0] cmd_scalar;
  logic [1:0]  cmd_group;
  logic        vec_we;
  logic [2:0]  vec_addr_rd, vec_addr_rs, vec_addr_rt;
  logic [3:0]  aluOp;
  logic [4:0]  shamt;
  logic        useSign, use_scalar;
  logic [31:0] scalar_val;
  logic        vec_zero;
  logic        zero_valid, zero_flag, busy;

  always #5 clk = ~clk;

  vec_issue_ctrl #(.DEPTH(4), .REG_AW(3)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_rd(cmd_rd), .cmd_rs(cmd_rs), .cmd_rt(cmd_rt),
    .cmd_shamt(cmd_shamt), .cmd_sign(cmd_sign), .cmd_use_scalar(cmd_use_scalar),
    .cmd_scalar(cmd_scalar), .cmd_group(cmd_group),
    .vec_we(vec_we), .vec_addr_rd(vec_addr_rd), .vec_addr_rs(vec_addr_rs),
    .vec_addr_rt(vec_addr_rt), .aluOp(aluOp), .shamt(shamt), .useSign(useSign),
    .scalar_val(scalar_val), .use_scalar(use_scalar), .vec_zero(vec_zero),
    .zero_valid(zero_valid), .zero_flag(zero_flag), .busy(busy)
  );

  typedef struct {
    logic [2:0]  rd, rs, rt;
    logic [3:0]  op;
    logic [4:0]  sh;
    logic        sg, us;
    logic [31:0] sc;
    logic        z, contig;
  } beat_t;

  beat_t bq[$];
  logic  zq[$];
  int    checks = 0;
  int    errors = 0;
  int    pulses = 0;
  int    w, wsum;

  task automatic exp_beat(input logic [2:0] rd, rs, rt, input logic [3:0] op,
                          input logic [4:0] sh, input logic sg, us,
                          input logic [31:0] sc, input logic z, contig);
    beat_t b;
    b.rd = rd; b.rs = rs; b.rt = rt; b.op = op; b.sh = sh;
    b.sg = sg; b.us = us; b.sc = sc; b.z = z; b.contig = contig;
    bq.push_back(b);
  endtask

  task automatic send(input logic [3:0] op, input logic [2:0] rd, rs, rt,
                      input logic [4:0] sh, input logic sg, us,
                      input logic [31:0] sc, input logic [1:0] grp,
                      output int waits);
    logic ok;
    cmd_valid = 1'b1; cmd_op = op; cmd_rd = rd; cmd_rs = rs; cmd_rt = rt;
    cmd_shamt = sh; cmd_sign = sg; cmd_use_scalar = us; cmd_scalar = sc;
    cmd_group = grp;
    waits = 0;
    forever begin
      @(negedge clk);
      ok = cmd_ready;
      @(posedge clk);
      if (ok) break;
      waits++;
      if (waits > 50) begin
        checks++; errors++;
        $display("FAIL send_timeout waited %0d cycles, required acceptance", waits);
        break;
      end
    end
    #1;
  endtask

  task automatic idle_in();
    cmd_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((busy || zero_valid || bq.size() != 0 || zq.size() != 0) && n < 200) begin
      @(posedge clk);
      n++;
    end
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (n >= 200) begin
      errors++;
      $display("FAIL drain_timeout busy=%0b beats_left=%0d zeros_left=%0d required all 0",
               busy, bq.size(), zq.size());
    end
  endtask

  task automatic check_zero_outputs(input string name);
    logic [63:0] act;
    act = {vec_we, use_scalar, useSign, zero_valid, zero_flag, busy,
           vec_addr_rd, vec_addr_rs, vec_addr_rt, aluOp, shamt, scalar_val};
    checks++;
    if (act !== '0 || cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s outputs=%h ready=%0b required outputs=0 ready=1", name, act, cmd_ready);
    end
  endtask

  // Monitor: every issued beat and every completion pulse is checked against the queues.
  initial begin
    beat_t e;
    logic  prev_we = 1'b0;
    logic  ez;
    logic [49:0] act, expv;
    forever begin
      @(negedge clk);
      if (vec_we === 1'b1) begin
        checks++;
        act = {vec_addr_rd, vec_addr_rs, vec_addr_rt, aluOp, shamt, useSign,
               use_scalar, scalar_val};
        if (bq.size() == 0) begin
          errors++;
          $display("FAIL beat_unexpected got %h required no beat", act);
        end else begin
          e = bq.pop_front();
          expv = {e.rd, e.rs, e.rt, e.op, e.sh, e.sg, e.us, e.sc};
          if (act !== expv || (e.contig && !prev_we)) begin
            errors++;
            $display("FAIL beat got %h prev_we=%0b required %h contig=%0b",
                     act, prev_we, expv, e.contig);
          end
          vec_zero = e.z;
        end
      end
      prev_we = vec_we;
      if (zero_valid === 1'b1) begin
        checks++;
        pulses++;
        if (zq.size() == 0) begin
          errors++;
          $display("FAIL zero_unexpected got pulse flag=%0b required no pulse", zero_flag);
        end else begin
          ez = zq.pop_front();
          if (zero_flag !== ez) begin
            errors++;
            $display("FAIL zero_flag got %0b required %0b", zero_flag, ez);
          end
        end
      end
    end
  end

  initial begin
    rst = 1'b0; cmd_valid = 1'b0; vec_zero = 1'b0;
    cmd_op = '0; cmd_rd = '0; cmd_rs = '0; cmd_rt = '0; cmd_shamt = '0;
    cmd_sign = 1'b0; cmd_use_scalar = 1'b0; cmd_scalar = '0; cmd_group = '0;
    #1;
    check_zero_outputs("reset_state");
    repeat (2) @(posedge clk);
    #3 rst = 1'b1;
    @(posedge clk); #1;

    // Single ADD, latency 1, zero flag 0.
    exp_beat(3, 1, 2, 0, 0, 0, 0, 0, 0, 0);
    zq.push_back(1'b0);
    send(0, 3, 1, 2, 0, 0, 0, 0, 0, w);
    idle_in();
    checks++;
    if (vec_we !== 1'b1 || vec_addr_rd !== 3'd3) begin
      errors++;
      $display("FAIL latency_we got we=%0b rd=%0d required we=1 rd=3", vec_we, vec_addr_rd);
    end
    @(posedge clk); #1;
    checks++;
    if (vec_we !== 1'b0 || zero_valid !== 1'b1 || zero_flag !== 1'b0) begin
      errors++;
      $display("FAIL single_done got we=%0b zv=%0b zf=%0b required 0 1 0",
               vec_we, zero_valid, zero_flag);
    end
    @(posedge clk); #1;
    checks++;
    if (zero_valid !== 1'b0) begin
      errors++;
      $display("FAIL pulse_width got zero_valid=%0b required 0", zero_valid);
    end
    drain();

    // Group of 4 with address wrap.
    exp_beat(6, 6, 6, 1, 0, 0, 0, 0, 1, 0);
    exp_beat(7, 7, 7, 1, 0, 0, 0, 0, 1, 1);
    exp_beat(0, 0, 0, 1, 0, 0, 0, 0, 1, 1);
    exp_beat(1, 1, 1, 1, 0, 0, 0, 0, 1, 1);
    zq.push_back(1'b1);
    send(1, 6, 6, 6, 0, 0, 0, 0, 3, w);
    idle_in();
    drain();

    // Scalar group: rt held, scalar and shift settings held.
    exp_beat(4, 1, 0, 1, 3, 1, 1, 5, 1, 0);
    exp_beat(5, 2, 0, 1, 3, 1, 1, 5, 1, 1);
    zq.push_back(1'b1);
    send(1, 4, 1, 0, 3, 1, 1, 5, 1, w);
    idle_in();
    drain();

    // Mixed zero across 3 beats.
    exp_beat(2, 3, 5, 3, 0, 0, 0, 0, 1, 0);
    exp_beat(3, 4, 6, 3, 0, 0, 0, 0, 0, 1);
    exp_beat(4, 5, 7, 3, 0, 0, 0, 0, 1, 1);
    zq.push_back(1'b0);
    send(3, 2, 3, 5, 0, 0, 0, 0, 2, w);
    idle_in();
    drain();

    // Back-to-back: FIFO fills after the 6th accept; 7th command stalls 3 cycles.
    for (int i = 0; i < 7; i++) begin
      for (int k = 0; k < 4; k++)
        exp_beat(3'(i + k), 3'(i + k), 3'(i + k), 4'(i), 0, 0, 0, 32'(i), 1,
                 (i != 0 || k != 0));
      zq.push_back(1'b1);
    end
    wsum = 0;
    for (int i = 0; i < 7; i++) begin
      send(4'(i), 3'(i), 3'(i), 3'(i), 0, 0, 0, 32'(i), 3, w);
      if (i < 6) wsum += w;
    end
    idle_in();
    checks++;
    if (wsum != 0 || w != 3) begin
      errors++;
      $display("FAIL backpressure got early_waits=%0d last_wait=%0d required 0 and 3", wsum, w);
    end
    drain();

    // Reset during beat 1 of a 4-beat group.
    exp_beat(1, 2, 3, 2, 0, 0, 0, 0, 1, 0);
    send(2, 1, 2, 3, 0, 0, 0, 0, 3, w);
    idle_in();
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    check_zero_outputs("reset_midgroup");
    repeat (2) @(posedge clk);
    #3 rst = 1'b1;
    @(posedge clk); #1;
    exp_beat(7, 0, 1, 4, 0, 0, 0, 0, 1, 0);
    zq.push_back(1'b1);
    send(4, 7, 0, 1, 0, 0, 0, 0, 0, w);
    idle_in();
    drain();

    checks++;
    if (pulses != 12 || bq.size() != 0 || zq.size() != 0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL final got pulses=%0d beats_left=%0d zeros_left=%0d busy=%0b required 12 0 0 0",
               pulses, bq.size(), zq.size(), busy);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
